// File: rtl/instr_fetch_unit_pkg.sv
// Shared sizing constants for the instruction fetch unit and its queue.
// Tops take these as parameter defaults so a core can override them per instance.
package instr_fetch_unit_pkg;

    localparam int              IFU_ADDR_SIZE    = 32'd32;
    localparam int              IFU_INSTR_SIZE   = 32'd32;
    localparam logic [31:0]     IFU_RESET_VECTOR = 32'h0000_0000;
    localparam int              IFU_QUEUE_DEPTH  = 32'd4;
    localparam int              IFU_PC_STEP      = 32'd4;

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Synchronous in-order FIFO holding fetched {pc, instr} entries.
// Flush clears occupancy and pointers; entry storage itself is never reset.
module fetch_queue #(
    parameter int WIDTH = 32'd64,
    parameter int DEPTH = 32'd4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

endmodule : fetch_queue

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, drives IMem, and buffers {pc, instr} for decode.
// Redirects flush everything and restart at the word-aligned target; halt only stops fetching.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                       ADDR_SIZE   = IFU_ADDR_SIZE,
    parameter int                       INSTR_SIZE  = IFU_INSTR_SIZE,
    parameter int                       QUEUE_DEPTH = IFU_QUEUE_DEPTH,
    parameter logic [ADDR_SIZE-1:0]     RESET_PC    = ADDR_SIZE'(IFU_RESET_VECTOR)
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic [ADDR_SIZE-1:0]            imemAddr,
    input  logic [INSTR_SIZE-1:0]           imemData,
    input  logic                            halt,
    input  logic                            redirectValid,
    input  logic [ADDR_SIZE-1:0]            redirectTarget,
    output logic                            instrValid,
    input  logic                            instrReady,
    output logic [INSTR_SIZE-1:0]           instr,
    output logic [ADDR_SIZE-1:0]            instrPC,
    output logic [$clog2(QUEUE_DEPTH):0]    queueCount
);

    localparam int                   ENTRY_W  = ADDR_SIZE + INSTR_SIZE;
    localparam logic [ADDR_SIZE-1:0] PC_STEP  = ADDR_SIZE'(IFU_PC_STEP);
    localparam logic [ADDR_SIZE-1:0] LOW_MASK = ADDR_SIZE'(2'b11);

    function automatic logic [ADDR_SIZE-1:0] align_word(input logic [ADDR_SIZE-1:0] addr);
        return addr & ~LOW_MASK;
    endfunction

    logic [ADDR_SIZE-1:0]           r_fetch_pc;
    logic                           w_enq;
    logic                           w_deq;
    logic                           w_full;
    logic                           w_empty;
    logic [ENTRY_W-1:0]             w_head;
    logic [$clog2(QUEUE_DEPTH):0]   w_count;

    // A full queue may still accept a fetch when the head leaves in the same cycle.
    assign instrValid = !w_empty && !redirectValid;
    assign w_deq      = instrValid && instrReady;
    assign w_enq      = !rst && !halt && !redirectValid && (!w_full || w_deq);

    // Fetch PC: redirect beats everything, including halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirectValid) begin
            r_fetch_pc <= align_word(redirectTarget);
        end else if (w_enq) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_enq),
        .i_pop   (w_deq),
        .i_flush (redirectValid),
        .i_wdata ({r_fetch_pc, imemData}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign imemAddr   = r_fetch_pc;
    assign instrPC    = w_head[ENTRY_W-1 -: ADDR_SIZE];
    assign instr      = w_head[INSTR_SIZE-1:0];
    assign queueCount = w_count;

endmodule : instr_fetch_unit
